// File: rtl/hamming_corrector.sv
// Hamming(7,4) receive-side corrector: syndrome, single-bit fix, 2-stage valid/ready pipeline.
// Optional saturating corrected-word counter enabled by defining HAMMING_ERR_COUNT_EN.
module hamming_corrector #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic [2:0]       syndrome,
  output logic             corrected
`ifdef HAMMING_ERR_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
`endif
);

  logic       s1_valid_q, s1_valid_d;
  logic [6:0] s1_code_q, s1_code_d;
  logic [2:0] s1_syn_q, s1_syn_d;
  logic       s2_valid_q, s2_valid_d;
  logic [3:0] data_q, data_d;
  logic [2:0] syn_q, syn_d;
  logic       corr_q, corr_d;

  logic       s2_adv, s1_adv;
  logic [2:0] in_syn;
  logic [6:0] flip_mask;
  logic [6:0] fixed_code;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;

    in_syn[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
    in_syn[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
    in_syn[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];

    // Syndrome S points at Hamming position S, i.e. bit S-1; S=0 yields an empty mask.
    flip_mask = '0;
    for (int i = 0; i < 7; i++) begin
      flip_mask[i] = (s1_syn_q == 3'(i + 1));
    end
    fixed_code = s1_code_q ^ flip_mask;

    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    syn_d      = syn_q;
    corr_d     = corr_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = code_in;
        s1_syn_d  = in_syn;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
        syn_d  = s1_syn_q;
        corr_d = |s1_syn_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      syn_q      <= '0;
      corr_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_syn_q   <= s1_syn_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      syn_q      <= syn_d;
      corr_q     <= corr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign data_out  = data_q;
  assign syndrome  = syn_q;
  assign corrected = corr_q;

`ifdef HAMMING_ERR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts on the S1->S2 transfer; clear wins over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s2_adv && s1_valid_q && (|s1_syn_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_hamming_corrector.sv
// Scoreboard bench for hamming_corrector: directed vectors, full error sweep, backpressure, reset.
// Counter checks are compiled in when HAMMING_ERR_COUNT_EN is defined (counter width 2).
module tb_hamming_corrector;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] code_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  logic       corrected;

  int checks;
  int failures;
  exp_t sb_q[$];

`ifdef HAMMING_ERR_COUNT_EN
  logic       cnt_clr;
  logic [1:0] err_count;

  hamming_corrector #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .corrected(corrected),
    .cnt_clr(cnt_clr), .err_count(err_count)
  );
`else
  hamming_corrector dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .corrected(corrected)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: data bits at positions 3,5,6,7; parity at 1,2,4.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c    = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = c[2] ^ c[4] ^ c[6];
    c[1] = c[2] ^ c[5] ^ c[6];
    c[3] = c[4] ^ c[5] ^ c[6];
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one word, waits (bounded) for acceptance, and records its expected result.
  task automatic applyStimulus(input logic [6:0] code, input exp_t exp);
    int n;
    in_valid = 1'b1;
    code_in  = code;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 for code 0x%0h", code);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: %0d words outstanding, expected 0", sb_q.size());
    end
  endtask

  // Monitor: every word the DUT hands over is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_output: got data 0x%0h syn %0d, expected no output", data_out, syndrome);
        end else begin
          e = sb_q.pop_front();
          if (data_out !== e.data || syndrome !== e.syn || corrected !== e.corr) begin
            failures++;
            $display("[TB] FAIL scoreboard: got data 0x%0h syn %0d corr %0b, expected data 0x%0h syn %0d corr %0b",
                     data_out, syndrome, corrected, e.data, e.syn, e.corr);
          end
        end
      end
    end
  end

  initial begin
    exp_t w1, w2, w3;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    code_in   = '0;
    out_ready = 1'b1;
`ifdef HAMMING_ERR_COUNT_EN
    cnt_clr   = 1'b0;
`endif
    #1;
    checkOutput("reset_out_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("reset_data_out", {4'd0, data_out}, 8'd0);
    checkOutput("reset_corrected", {7'd0, corrected}, 8'd0);
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("post_reset_in_ready", {7'd0, in_ready}, 8'd1);
    checkOutput("post_reset_out_valid", {7'd0, out_valid}, 8'd0);

    // Clean word, with explicit two-cycle latency check.
    applyStimulus(7'b1010101, '{data: 4'b1011, syn: 3'b000, corr: 1'b0});
    checkOutput("latency_cycle1_out_valid", {7'd0, out_valid}, 8'd0);
    @(posedge clk); #1;
    checkOutput("latency_cycle2_out_valid", {7'd0, out_valid}, 8'd1);
    applyStimulus(7'b1010100, '{data: 4'b1011, syn: 3'b001, corr: 1'b1});
    applyStimulus(7'b1011101, '{data: 4'b1011, syn: 3'b100, corr: 1'b1});
    applyStimulus(7'b1010110, '{data: 4'b1010, syn: 3'b011, corr: 1'b1});
    waitDrain();

    // Every data value clean, then with each single position flipped, back to back.
    for (int d = 0; d < 16; d++) begin
      applyStimulus(encode(4'(d)), '{data: 4'(d), syn: 3'd0, corr: 1'b0});
      for (int p = 0; p < 7; p++) begin
        applyStimulus(encode(4'(d)) ^ (7'd1 << p), '{data: 4'(d), syn: 3'(p + 1), corr: 1'b1});
      end
    end
    waitDrain();

    // Backpressure: two words fill the pipeline, the third must wait.
    w1 = '{data: 4'h3, syn: 3'd6, corr: 1'b1};
    w2 = '{data: 4'hC, syn: 3'd0, corr: 1'b0};
    w3 = '{data: 4'h9, syn: 3'd7, corr: 1'b1};
    out_ready = 1'b0;
    applyStimulus(encode(4'h3) ^ 7'b0100000, w1);
    applyStimulus(encode(4'hC), w2);
    in_valid = 1'b1;
    code_in  = encode(4'h9) ^ 7'b1000000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", {7'd0, in_ready}, 8'd0);
      checkOutput("stall_out_valid", {7'd0, out_valid}, 8'd1);
      checkOutput("stall_data_hold", {4'd0, data_out}, {4'd0, w1.data});
      checkOutput("stall_syn_hold", {5'd0, syndrome}, {5'd0, w1.syn});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    applyStimulus(encode(4'h9) ^ 7'b1000000, w3);
    waitDrain();

`ifdef HAMMING_ERR_COUNT_EN
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    checkOutput("cnt_clear_idle", {6'd0, err_count}, 8'd0);
    applyStimulus(encode(4'h1) ^ 7'b0000001, '{data: 4'h1, syn: 3'd1, corr: 1'b1});
    applyStimulus(encode(4'h2) ^ 7'b0000010, '{data: 4'h2, syn: 3'd2, corr: 1'b1});
    waitDrain();
    checkOutput("cnt_after_two", {6'd0, err_count}, 8'd2);
    applyStimulus(encode(4'h4) ^ 7'b0000100, '{data: 4'h4, syn: 3'd3, corr: 1'b1});
    applyStimulus(encode(4'h5) ^ 7'b0001000, '{data: 4'h5, syn: 3'd4, corr: 1'b1});
    applyStimulus(encode(4'h6) ^ 7'b0010000, '{data: 4'h6, syn: 3'd5, corr: 1'b1});
    waitDrain();
    checkOutput("cnt_saturate", {6'd0, err_count}, 8'd3);
    // Clear lands on the same edge as a corrupted word's S1->S2 transfer.
    applyStimulus(encode(4'h7) ^ 7'b1000000, '{data: 4'h7, syn: 3'd7, corr: 1'b1});
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    checkOutput("cnt_clr_priority", {6'd0, err_count}, 8'd0);
    applyStimulus(encode(4'h8) ^ 7'b0000001, '{data: 4'h8, syn: 3'd1, corr: 1'b1});
    waitDrain();
    checkOutput("cnt_after_clear", {6'd0, err_count}, 8'd1);
`endif

    // Asynchronous reset mid-stream, between clock edges.
    applyStimulus(encode(4'hA) ^ 7'b0000100, '{data: 4'hA, syn: 3'd3, corr: 1'b1});
    applyStimulus(encode(4'h5), '{data: 4'h5, syn: 3'd0, corr: 1'b0});
    checkOutput("pre_reset_out_valid", {7'd0, out_valid}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("async_reset_data_out", {4'd0, data_out}, 8'd0);
    checkOutput("async_reset_syndrome", {5'd0, syndrome}, 8'd0);
`ifdef HAMMING_ERR_COUNT_EN
    checkOutput("async_reset_err_count", {6'd0, err_count}, 8'd0);
`endif
    sb_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rerelease_in_ready", {7'd0, in_ready}, 8'd1);
    applyStimulus(encode(4'hE) ^ 7'b0010000, '{data: 4'hE, syn: 3'd5, corr: 1'b1});
    checkOutput("post_reset_cycle1_out_valid", {7'd0, out_valid}, 8'd0);
    @(posedge clk); #1;
    checkOutput("post_reset_cycle2_out_valid", {7'd0, out_valid}, 8'd1);
    checkOutput("post_reset_cycle2_data", {4'd0, data_out}, 8'h0E);
    waitDrain();

    checkOutput("scoreboard_empty", 8'(sb_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
